iob_2p_asym_fifo_ctrl: RTL
==========================

// Module: iob_2p_asym_fifo_ctrl
// PURPOSE
//  Single-clock FIFO controller that sequences one iob_2p_assim_mem instance
//  (write port W_DATA_W wide, read port R_DATA_W wide) as a width-converting FIFO.
//  Owns the write/read pointers, full/empty/level status and the read-valid pipeline.
//  Drives the memory ports directly. The memory itself is instantiated beside this
//  block by the FIFO top level.
// PARAMETERS
//  W_DATA_W  32  write-side word width; power-of-two multiple or divisor of R_DATA_W
//  R_DATA_W   8  read-side word width
//  ADDR_W     4  log2 of capacity counted in narrow (MIN_W) words; capacity = 2^ADDR_W
//  derived: MIN_W=min(W,R); W_RATIO=W_DATA_W/MIN_W; R_RATIO=R_DATA_W/MIN_W;
//           W_ADDR_W=ADDR_W-log2(W_RATIO); R_ADDR_W=ADDR_W-log2(R_RATIO)
// PORTS
//  clk         in   1         clock, rising edge
//  rst_n       in   1         asynchronous reset, active low
//  clear       in   1         synchronous soft flush, active high
//  w_en        in   1         push request; w_data sampled when w_en & ~w_full
//  w_data      in   W_DATA_W  push data
//  w_full      out  1         cannot accept one more W_DATA_W word
//  r_en        in   1         pop request; accepted when r_en & ~r_empty
//  r_data      out  R_DATA_W  pop data, valid when r_valid
//  r_valid     out  1         pulses 1 cycle after an accepted pop
//  r_empty     out  1         fewer than R_RATIO narrow words stored
//  level       out  ADDR_W+1  occupancy in narrow words, 0..2^ADDR_W
//  mem_w_en    out  1         to memory w_en
//  mem_w_addr  out  W_ADDR_W  to memory w_addr
//  mem_data_in out  W_DATA_W  to memory data_in
//  mem_r_en    out  1         to memory r_en
//  mem_r_addr  out  R_ADDR_W  to memory r_addr
//  mem_data_out in  R_DATA_W  from memory data_out (registered, 1-cycle latency)
// BEHAVIOUR
//  - Reset (rst_n=0, async): wptr=rptr=0, level=0, r_empty=1, w_full=0, r_valid=0.
//    Memory contents are not touched; all stored data is discarded. The same holds when
//    reset is asserted mid-transfer: an in-flight r_valid is squashed.
//  - wptr/rptr: ADDR_W+1 bits, in narrow-word units. A push adds W_RATIO; a pop adds
//    R_RATIO. Both wrap modulo 2^(ADDR_W+1). Addresses stay ratio-aligned by construction.
//  - mem_w_addr=wptr[ADDR_W-1:log2(W_RATIO)]; mem_r_addr=rptr[ADDR_W-1:log2(R_RATIO)].
//  - Packing: narrow word k of a wide word sits at bits [k*MIN_W +: MIN_W]. The lowest
//    narrow address is in the LSBs, so FIFO order is LSB-first.
//  - Push accepted iff w_en & ~w_full: mem_w_en=1 and mem_data_in=w_data in the same
//    cycle (combinational pass-through). wptr advances at the edge.
//  - Pop accepted iff r_en & ~r_empty: mem_r_en=1 in the same cycle. rptr advances at the
//    edge. r_valid=1 in the next cycle, with r_data=mem_data_out.
//  - Rejected requests (push when full, pop when empty) are ignored: no pointer or
//    memory-enable change.
//  - level = wptr - rptr (mod 2^(ADDR_W+1)), registered.
//    w_full  = level > 2^ADDR_W - W_RATIO.  r_empty = level < R_RATIO.
//    Both are registered, computed from the next-state level.
//  - Simultaneous accepted push and pop: both take effect; level += W_RATIO - R_RATIO.
//    There is no read/write collision, because a pop only reads narrow words that
//    were written in earlier cycles.
//  - Partial data: if level < R_RATIO (narrow-to-wide build-up), r_empty stays 1 until a
//    full read word exists.
//  - clear: next edge sets wptr=rptr=level=0, r_empty=1, w_full=0, r_valid=0.
//    clear takes priority over same-cycle push/pop; those are dropped.
//  - Latency: push-to-r_empty deassert = 1 cycle (when a full read word completes).
//    Pop-to-r_valid = 1 cycle. Sustained throughput = one push and one pop per cycle.
// STRUCTURE
//  - Shared header iob_fifo_defs.vh: a clog2 macro, plus MIN_W and ratio/address-width
//    derivation macros reused by the future iob_2p_asym_fifo top.
//  - No sub-module inside this block. Pointer/level logic is flat.
//  - The sibling wrapper iob_2p_asym_fifo instantiates this block plus iob_2p_assim_mem.
// TESTING (bench = iob_2p_asym_fifo with the real memory)
//  1. W=32,R=8,ADDR_W=4: after reset, check r_empty=1, w_full=0, level=0.
//     Push 0x23222120 .. 0x2F2E2D2C (4 words) -> w_full=1, level=16.
//     Then 16 pops -> r_data = 0x20..0x2F in order, r_valid 1 cycle after each r_en,
//     r_empty=1 at the end.
//  2. W=8,R=32,ADDR_W=4: push 0x20,0x21,0x22 -> r_empty stays 1, level=3.
//     Push 0x23 -> r_empty=0 next cycle. Pop -> r_data=0x23222120.
//  3. Full/empty guards: push while w_full=1 -> level unchanged, mem_w_en=0.
//     Pop while r_empty=1 -> mem_r_en=0, no r_valid.
//  4. Wrap: 40 push/pop pairs at steady level 8 (W=32,R=8 interleaved 1:4) -> data order
//     preserved across pointer wrap; level never exceeds 16.
//  5. Simultaneous push+pop at level=4 (W=32,R=8) -> next level=7, popped byte correct.
//  6. Mid-stream clear, then async rst_n pulse during an accepted pop -> level=0,
//     r_empty=1, r_valid never asserted for the squashed pop. A subsequent push/pop
//     returns fresh data only.

Source files
------------

// File: rtl/iob_2p_asym_fifo_ctrl_pkg.sv
// Shared helpers for the asymmetric-width FIFO family.
// Provides constant functions used to derive the narrow word width, the
// port ratios and the per-port address widths from the top-level parameters,
// plus the accept-strobe bundle used inside the controller.
package iob_2p_asym_fifo_ctrl_pkg;

    // Narrow word width: the smaller of the two port widths.
    function automatic int fifo_min_w(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Ceiling log2 for elaboration-time constants (ratios are powers of two).
    function automatic int fifo_log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Requests that were actually accepted this cycle.
    typedef struct packed {
        logic push;
        logic pop;
    } fifo_acc_t;

endpackage

// File: rtl/iob_2p_asym_fifo_ctrl.sv
// Single-clock controller for a width-converting FIFO built on a two-port
// asymmetric memory (write port W_DATA_W wide, read port R_DATA_W wide).
// Owns the read/write pointers, occupancy level, full/empty flags and the
// one-cycle read-valid pipeline; the memory sits beside this block.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   clear             synchronous flush, overrides same-cycle push/pop
//   w_en, w_data      push request / data;   w_full  : no room for a wide word
//   r_en              pop request;           r_empty : less than one read word
//   r_data, r_valid   pop data, valid one cycle after an accepted pop
//   level             occupancy counted in narrow words (0..2^ADDR_W)
//   mem_*             direct drive of the memory ports; mem_data_out has a
//                     registered one-cycle read latency
module iob_2p_asym_fifo_ctrl
    import iob_2p_asym_fifo_ctrl_pkg::*;
#(
    parameter  int W_DATA_W = 32,
    parameter  int R_DATA_W = 8,
    parameter  int ADDR_W   = 4,
    localparam int MIN_W    = fifo_min_w(W_DATA_W, R_DATA_W),
    localparam int W_RATIO  = W_DATA_W / MIN_W,
    localparam int R_RATIO  = R_DATA_W / MIN_W,
    localparam int W_SH     = fifo_log2(W_RATIO),
    localparam int R_SH     = fifo_log2(R_RATIO),
    localparam int W_ADDR_W = ADDR_W - W_SH,
    localparam int R_ADDR_W = ADDR_W - R_SH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_valid,
    output logic                r_empty,
    output logic [ADDR_W:0]     level,
    output logic                mem_w_en,
    output logic [W_ADDR_W-1:0] mem_w_addr,
    output logic [W_DATA_W-1:0] mem_data_in,
    output logic                mem_r_en,
    output logic [R_ADDR_W-1:0] mem_r_addr,
    input  logic [R_DATA_W-1:0] mem_data_out
);

    // Pointer arithmetic is done in narrow-word units, one extra bit wide so
    // that full (level = 2^ADDR_W) and empty (level = 0) are distinguishable.
    localparam logic [ADDR_W:0] W_INC   = (ADDR_W+1)'(W_RATIO);
    localparam logic [ADDR_W:0] R_INC   = (ADDR_W+1)'(R_RATIO);
    localparam logic [ADDR_W:0] CAP     = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] FULL_TH = CAP - W_INC;

    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] rptr_q, rptr_d;
    logic [ADDR_W:0] level_q, level_d;
    logic            w_full_q, w_full_d;
    logic            r_empty_q, r_empty_d;
    logic            r_valid_q, r_valid_d;
    fifo_acc_t       acc;

    always_comb begin
        // clear drops any same-cycle request, including the memory strobes.
        acc.push = w_en & ~w_full_q & ~clear;
        acc.pop  = r_en & ~r_empty_q & ~clear;

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (acc.push) wptr_d = wptr_q + W_INC;
            if (acc.pop)  rptr_d = rptr_q + R_INC;
        end

        // Flags are registered from the next-state level so they are valid
        // in the same cycle the new level appears.
        level_d   = wptr_d - rptr_d;
        w_full_d  = level_d > FULL_TH;
        r_empty_d = level_d < R_INC;
        r_valid_d = acc.pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            w_full_q  <= 1'b0;
            r_empty_q <= 1'b1;
            r_valid_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            w_full_q  <= w_full_d;
            r_empty_q <= r_empty_d;
            r_valid_q <= r_valid_d;
        end
    end

    // Pointers are always ratio-aligned, so dropping the low bits gives the
    // port address directly.
    assign mem_w_en    = acc.push;
    assign mem_w_addr  = wptr_q[ADDR_W-1:W_SH];
    assign mem_data_in = w_data;
    assign mem_r_en    = acc.pop;
    assign mem_r_addr  = rptr_q[ADDR_W-1:R_SH];

    assign r_data  = mem_data_out;
    assign r_valid = r_valid_q;
    assign r_empty = r_empty_q;
    assign w_full  = w_full_q;
    assign level   = level_q;

endmodule
